// File: rtl/ahfp_norm48_if.sv
// Handshake/data bundle for the AHFP 48-bit normalise/round/pack stage.
// slave = the normaliser, master = its upstream producer and downstream consumer.
interface ahfp_norm48_if #(
  parameter int EXP_W = 10
);
  logic             in_valid;
  logic             in_ready;
  logic [47:0]      mant_in;
  logic [5:0]       lz_in;
  logic             lz_valid;
  logic [EXP_W-1:0] exp_in;
  logic             sign_in;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      result;

  modport slave (
    input  in_valid, mant_in, lz_in, lz_valid, exp_in, sign_in, out_ready,
    output in_ready, out_valid, result
  );

  modport master (
    output in_valid, mant_in, lz_in, lz_valid, exp_in, sign_in, out_ready,
    input  in_ready, out_valid, result
  );
endinterface

// File: rtl/ahfp_norm48.sv
// Two-stage normalise (shift) and round/pack to IEEE-754 single, valid/ready pipelined.
// Define AHFP_NORM_RNE_EN for round-nearest-even; otherwise the fraction is truncated.
module ahfp_norm48 #(
  parameter int EXP_W = 10
) (
  input  logic          clk,
  input  logic          reset,
  ahfp_norm48_if.slave  io
);
  localparam int EW1 = EXP_W + 1;
  localparam int EW2 = EXP_W + 2;
  localparam logic signed [EW2-1:0] EMAX = EW2'(255);

  logic                  r_s1_valid;
  logic [47:0]           r_s1_m;
  logic signed [EW1-1:0] r_s1_e;
  logic                  r_s1_sign;
  logic                  r_s1_zero;
  logic                  r_s2_valid;
  logic [31:0]           r_result;

  logic                  w_s2_adv;
  logic                  w_in_ready;
  logic [47:0]           w_s1_m;
  logic signed [EW1-1:0] w_s1_e;
  logic                  w_s1_zero;
  logic [22:0]           w_frac;
  logic                  w_inc;
  logic                  w_carry;
  logic [22:0]           w_frac_r;
  logic signed [EW2-1:0] w_e2;
  logic [31:0]           w_pack;
  logic                  w_unused;

  assign w_s2_adv   = !r_s2_valid || io.out_ready;
  assign w_in_ready = !r_s1_valid || w_s2_adv;

  assign io.in_ready  = w_in_ready;
  assign io.out_valid = r_s2_valid;
  assign io.result    = r_result;

  // Stage 1: bring the leading one to bit 47; exponent tracks the shift.
  assign w_s1_m    = io.mant_in << io.lz_in;
  assign w_s1_e    = $signed({io.exp_in[EXP_W-1], io.exp_in}) + EW1'(1)
                   - $signed({{(EXP_W-5){1'b0}}, io.lz_in});
  assign w_s1_zero = !io.lz_valid || (io.lz_in > 6'd47);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_s1_valid <= 1'b0;
      r_s1_m     <= '0;
      r_s1_e     <= '0;
      r_s1_sign  <= 1'b0;
      r_s1_zero  <= 1'b0;
    end else if (w_in_ready) begin
      r_s1_valid <= io.in_valid;
      if (io.in_valid) begin
        r_s1_m    <= w_s1_m;
        r_s1_e    <= w_s1_e;
        r_s1_sign <= io.sign_in;
        r_s1_zero <= w_s1_zero;
      end
    end
  end

  // Stage 2: round, then classify; bit 47 is the implicit one.
  assign w_frac = r_s1_m[46:24];
`ifdef AHFP_NORM_RNE_EN
  assign w_inc    = r_s1_m[23] && ((|r_s1_m[22:0]) || r_s1_m[24]);
  assign w_unused = r_s1_m[47];
`else
  assign w_inc    = 1'b0;
  assign w_unused = &{r_s1_m[47], r_s1_m[23:0]};
`endif
  assign w_carry  = (&w_frac) && w_inc;
  assign w_frac_r = w_frac + 23'(w_inc);
  assign w_e2     = $signed({r_s1_e[EW1-1], r_s1_e}) + $signed({{(EW2-1){1'b0}}, w_carry});

  always_comb begin
    w_pack = {r_s1_sign, w_e2[7:0], w_frac_r};
    if (r_s1_zero)            w_pack = {r_s1_sign, 31'h0};
    else if (w_e2 <= EW2'(0)) w_pack = {r_s1_sign, 31'h0};
    else if (w_e2 >= EMAX)    w_pack = {r_s1_sign, 8'hFF, 23'h0};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_s2_valid <= 1'b0;
      r_result   <= 32'h0;
    end else if (w_s2_adv) begin
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) r_result <= w_pack;
    end
  end
endmodule

// File: tb/tb_ahfp_norm48.sv
// Directed checks of ahfp_norm48: vector table, back-pressure stall and mid-flight reset.
module tb_ahfp_norm48;
`ifdef AHFP_NORM_RNE_EN
  localparam bit RNE = 1'b1;
`else
  localparam bit RNE = 1'b0;
`endif

  typedef struct {
    logic [47:0] mant;
    logic [5:0]  lz;
    logic        lzv;
    logic [9:0]  exp;
    logic        sgn;
    logic [31:0] res;
  } vec_t;

  logic clk = 1'b0;
  logic reset;
  int   tests = 0;
  int   fails = 0;

  ahfp_norm48_if #(.EXP_W(10)) bus ();
  ahfp_norm48 #(.EXP_W(10)) dut (.clk(clk), .reset(reset), .io(bus));

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input vec_t v, input logic vld);
    bus.in_valid = vld;
    bus.mant_in  = v.mant;
    bus.lz_in    = v.lz;
    bus.lz_valid = v.lzv;
    bus.exp_in   = v.exp;
    bus.sign_in  = v.sgn;
  endtask

  vec_t vt[16];
  vec_t bt[4];
  vec_t idle;

  initial begin
    vt[0]  = '{48'h4000_0000_0000, 6'd1,  1'b1, 10'd127, 1'b0, 32'h3F80_0000};
    vt[1]  = '{48'h8000_0000_0000, 6'd0,  1'b1, 10'd127, 1'b0, 32'h4000_0000};
    vt[2]  = '{48'h7FFF_FFC0_0000, 6'd1,  1'b1, 10'd127, 1'b0, RNE ? 32'h4000_0000 : 32'h3FFF_FFFF};
    vt[3]  = '{48'h7FFF_FF80_0000, 6'd1,  1'b1, 10'd127, 1'b0, 32'h3FFF_FFFF};
    vt[4]  = '{48'h0000_0000_0000, 6'd0,  1'b0, 10'd127, 1'b1, 32'h8000_0000};
    vt[5]  = '{48'h4000_0000_0000, 6'd1,  1'b1, 10'd0,   1'b0, 32'h0000_0000};
    vt[6]  = '{48'h4000_0000_0000, 6'd1,  1'b1, 10'd300, 1'b0, 32'h7F80_0000};
    vt[7]  = '{48'h0000_0000_0001, 6'd47, 1'b1, 10'd174, 1'b1, 32'hC000_0000};
    vt[8]  = '{48'h8000_0080_0000, 6'd0,  1'b1, 10'd127, 1'b0, 32'h4000_0000};
    vt[9]  = '{48'h8000_0180_0000, 6'd0,  1'b1, 10'd127, 1'b0, RNE ? 32'h4000_0002 : 32'h4000_0001};
    vt[10] = '{48'h8000_0080_0001, 6'd0,  1'b1, 10'd127, 1'b0, RNE ? 32'h4000_0001 : 32'h4000_0000};
    vt[11] = '{48'h8000_0000_0000, 6'd0,  1'b1, 10'h3FB, 1'b0, 32'h0000_0000};
    vt[12] = '{48'h8000_0000_0000, 6'd0,  1'b1, 10'd253, 1'b0, 32'h7F00_0000};
    vt[13] = '{48'h8000_0000_0000, 6'd0,  1'b1, 10'd254, 1'b1, 32'hFF80_0000};
    vt[14] = '{48'hFFFF_FF80_0000, 6'd0,  1'b1, 10'd253, 1'b0, RNE ? 32'h7F80_0000 : 32'h7F7F_FFFF};
    vt[15] = '{48'h8000_0000_0000, 6'd0,  1'b1, 10'd0,   1'b0, 32'h0080_0000};

    bt[0] = '{48'h4000_0000_0000, 6'd1, 1'b1, 10'd127, 1'b0, 32'h3F80_0000};
    bt[1] = '{48'h8000_0000_0000, 6'd0, 1'b1, 10'd127, 1'b0, 32'h4000_0000};
    bt[2] = '{48'h8000_0000_0000, 6'd0, 1'b1, 10'd127, 1'b1, 32'hC000_0000};
    bt[3] = '{48'h8000_0000_0000, 6'd0, 1'b1, 10'd128, 1'b0, 32'h4080_0000};
    idle  = '{48'h0, 6'd0, 1'b0, 10'd0, 1'b0, 32'h0};

    reset = 1'b1;
    bus.out_ready = 1'b1;
    drive(idle, 1'b0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    chk("rst_out_valid", {31'h0, bus.out_valid}, 32'h0);
    chk("rst_result",    bus.result,            32'h0);
    chk("rst_in_ready",  {31'h0, bus.in_ready},  32'h1);

    // One beat at a time: out_valid must appear exactly two edges after acceptance.
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      drive(vt[i], 1'b1);
      @(posedge clk);
      @(negedge clk);
      drive(idle, 1'b0);
      chk($sformatf("vec%0d_lat1", i), {31'h0, bus.out_valid}, 32'h0);
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("vec%0d_valid", i), {31'h0, bus.out_valid}, 32'h1);
      chk($sformatf("vec%0d_res", i), bus.result, vt[i].res);
    end

    // Four back-to-back beats with out_ready low in cycles 2..4.
    begin
      logic [31:0] got[$];
      logic [31:0] prev;
      logic        held;
      logic        acc;
      int          k, stall_k, stab_err;
      k = 0; stall_k = -1; stab_err = 0; held = 1'b0; prev = '0;
      for (int c = 0; c < 30; c++) begin
        @(negedge clk);
        bus.out_ready = !(c >= 2 && c <= 4);
        if (k < 4) drive(bt[k], 1'b1);
        else       drive(idle, 1'b0);
        #1;
        if (bus.out_valid) begin
          if (held && bus.result !== prev) stab_err++;
          if (bus.out_ready) got.push_back(bus.result);
          held = !bus.out_ready;
          prev = bus.result;
        end else held = 1'b0;
        if (bus.in_valid && !bus.in_ready && stall_k < 0) stall_k = k;
        acc = bus.in_valid && bus.in_ready;
        @(posedge clk);
        if (acc) k++;
      end
      chk("b2b_stall_after", stall_k, 32'd2);
      chk("b2b_stable", stab_err, 32'd0);
      chk("b2b_count", got.size(), 32'd4);
      for (int i = 0; i < 4; i++)
        chk($sformatf("b2b_res%0d", i), (i < got.size()) ? got[i] : 32'hDEAD_BEEF, bt[i].res);
    end

    // Fill both stages, then reset: nothing from before the reset may emerge.
    begin
      int stale;
      stale = 0;
      @(negedge clk);
      bus.out_ready = 1'b0;
      drive(bt[0], 1'b1);
      @(posedge clk);
      @(negedge clk);
      drive(bt[1], 1'b1);
      @(posedge clk);
      @(negedge clk);
      drive(idle, 1'b0);
      chk("full_in_ready", {31'h0, bus.in_ready}, 32'h0);
      reset = 1'b1;
      @(posedge clk);
      @(negedge clk);
      chk("midrst_out_valid", {31'h0, bus.out_valid}, 32'h0);
      chk("midrst_result",    bus.result,            32'h0);
      chk("midrst_in_ready",  {31'h0, bus.in_ready},  32'h1);
      reset = 1'b0;
      bus.out_ready = 1'b1;
      for (int c = 0; c < 6; c++) begin
        @(negedge clk);
        if (bus.out_valid) stale++;
      end
      chk("midrst_no_stale", stale, 32'd0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
